// File: rtl/alu_arbiter_if.sv
// Requester/ALU bundle for alu_arbiter: two requester ports, captured response and shared-ALU drive.
// Handshake: reqX is a level held by the requester until gntX; gntX is a one-cycle pulse in the cycle the operands are taken.
interface alu_arbiter_if;
    logic        req0, req1;
    logic [31:0] a0, a1, b0, b1;
    logic [14:0] op0, op1;
    logic        gnt0, gnt1;
    logic        done0, done1;
    logic [31:0] result;
    logic        gt_out, eq_out, op_err;
    logic [31:0] alu_a, alu_b;
    logic [14:0] alu_bus;
    logic [31:0] alu_result;
    logic        alu_gt, alu_eq;
    logic        busy;
    logic [1:0]  dbg_state;

    modport slave (
        input  req0, req1, a0, a1, b0, b1, op0, op1, alu_result, alu_gt, alu_eq,
        output gnt0, gnt1, done0, done1, result, gt_out, eq_out, op_err,
               alu_a, alu_b, alu_bus, busy, dbg_state
    );

    modport master (
        output req0, req1, a0, a1, b0, b1, op0, op1, alu_result, alu_gt, alu_eq,
        input  gnt0, gnt1, done0, done1, result, gt_out, eq_out, op_err,
               alu_a, alu_b, alu_bus, busy, dbg_state
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority (requester 0 wins).
module alu_arbiter (
    input  logic clk,
    input  logic rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q;
    logic        owner_q;
    logic [2:0]  cnt_q;
    logic        bad_q;
    logic [31:0] alu_a_q, alu_b_q;
    logic [14:0] alu_bus_q;
    logic        done0_q, done1_q;
    logic [31:0] result_q;
    logic        gt_q, eq_q, op_err_q;
    logic        busy_q;
`ifdef ALU_ARB_RR_EN
    logic        rr_ptr_q;
`endif

    logic        pick0, pick1;
    logic [31:0] sel_a, sel_b;
    logic [14:0] sel_op;
    logic        sel_ok;
    logic [2:0]  sel_lat;

    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (state_q == IDLE) begin
`ifdef ALU_ARB_RR_EN
            // Pointer set means requester 1 is favoured on a tie.
            if (bus.req0 && (!bus.req1 || !rr_ptr_q)) pick0 = 1'b1;
            else if (bus.req1)                         pick1 = 1'b1;
`else
            if (bus.req0)      pick0 = 1'b1;
            else if (bus.req1) pick1 = 1'b1;
`endif
        end
        sel_a   = pick1 ? bus.a1  : bus.a0;
        sel_b   = pick1 ? bus.b1  : bus.b0;
        sel_op  = pick1 ? bus.op1 : bus.op0;
        sel_ok  = $onehot(sel_op);
        sel_lat = 3'd0;
        if (sel_ok && sel_op[2])                      sel_lat = 3'd3;
        else if (sel_ok && (sel_op[3] || sel_op[4]))  sel_lat = 3'd7;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            cnt_q     <= 3'd0;
            bad_q     <= 1'b0;
            alu_a_q   <= 32'd0;
            alu_b_q   <= 32'd0;
            alu_bus_q <= 15'd0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            result_q  <= 32'd0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            op_err_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ALU_ARB_RR_EN
            rr_ptr_q  <= 1'b0;
`endif
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick0 || pick1) begin
                        owner_q   <= pick1;
                        alu_a_q   <= sel_a;
                        alu_b_q   <= sel_b;
                        alu_bus_q <= sel_ok ? sel_op : 15'd0;
                        bad_q     <= !sel_ok;
                        cnt_q     <= sel_lat;
                        busy_q    <= 1'b1;
                        state_q   <= EXEC;
`ifdef ALU_ARB_RR_EN
                        rr_ptr_q  <= pick0;
`endif
                    end
                end
                EXEC: begin
                    if (cnt_q == 3'd0) begin
                        // A malformed op never reached the ALU, so its outputs are not trusted.
                        result_q  <= bad_q ? 32'd0 : bus.alu_result;
                        gt_q      <= bad_q ? 1'b0  : bus.alu_gt;
                        eq_q      <= bad_q ? 1'b0  : bus.alu_eq;
                        op_err_q  <= bad_q;
                        done0_q   <= !owner_q;
                        done1_q   <= owner_q;
                        alu_a_q   <= 32'd0;
                        alu_b_q   <= 32'd0;
                        alu_bus_q <= 15'd0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is taken in the IDLE cycle itself so operands are latched at that edge.
    assign bus.gnt0      = pick0 && !rst;
    assign bus.gnt1      = pick1 && !rst;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.result    = result_q;
    assign bus.gt_out    = gt_q;
    assign bus.eq_out    = eq_q;
    assign bus.op_err    = op_err_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_bus   = alu_bus_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports req0/req1  input  1  requester operation request; level signal, held until granted.
REQ-004 SHALL have ports a0/a1, b0/b1  input  32  requester operands.
REQ-005 SHALL have ports op0/op1  input  15  requester one-hot ALU op, bit map identical to the ALU's alu_bus: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6 and, 7 or, 8 not, 9 mov, 10 lsl, 11 lsr, 12 asr, 13 ld, 14 st.
REQ-006 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse; operands and op latched in that cycle.
REQ-007 SHALL have ports done0/done1  output  1  one-cycle completion pulse to the owning requester.
REQ-008 SHALL have ports result  output  32, gt_out  output  1, eq_out  output  1  captured ALU outputs, valid while doneX is high and held until the next capture.
REQ-009 SHALL have port op_err  output  1  high with doneX when the latched op was not one-hot.
REQ-010 SHALL have ports alu_a, alu_b  output  32, and alu_bus  output  15  drive to the shared ALU.
REQ-011 SHALL have ports alu_result  input  32, alu_gt  input  1, alu_eq  input  1  from the shared ALU.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-014 In IDLE with any reqX high, SHALL pulse exactly one gntX, latch aX/bX/opX and the owner ID, load the cycle counter, and go to EXEC.
REQ-015 With both requests high, SHALL grant per the arbitration policy (REQ-026/027).
REQ-016 A reqX dropped before its gntX SHALL be ignored with no grant.
REQ-017 In EXEC, SHALL drive alu_a/alu_b/alu_bus from the latched values; alu_bus SHALL be all-zero outside EXEC.
REQ-018 EXEC duration SHALL be 4 cycles for mul, 8 cycles for div or mod, and 1 cycle for all other ops.
REQ-019 The counter SHALL load latency-1 and decrement each EXEC cycle.
REQ-020 In the EXEC cycle where the counter is 0, SHALL capture alu_result/alu_gt/alu_eq into result/gt_out/eq_out and go to RESP.
REQ-021 In RESP, SHALL pulse doneX for the owner only and return to IDLE; no grant SHALL be issued in RESP.
REQ-022 Timing: gnt in cycle N, done in cycle N+1+latency (add: N+2; div: N+9).
REQ-023 An op that is zero or multi-hot SHALL still be granted, SHALL drive alu_bus with 0 during EXEC, SHALL take 1 cycle, and SHALL complete with result=0 and op_err=1.
REQ-024 Requests arriving while busy SHALL wait; they SHALL NOT be lost while held high.

Reset
REQ-025 On rst high, SHALL asynchronously force state IDLE, counter 0, RR pointer to requester 0, and all outputs (gnt, done, result, gt_out, eq_out, op_err, alu_*, busy) to 0; an operation in flight SHALL be abandoned with no done pulse.

Configuration
REQ-026 With ALU_ARB_RR_EN defined, SHALL use round-robin arbitration: a one-bit pointer favours the requester not granted last, updated on every grant.
REQ-027 Without ALU_ARB_RR_EN, SHALL use fixed priority, with requester 0 always winning ties.

Verification
REQ-028 SHALL cover: req0 add a=5, b=3 alone -> gnt0 cycle N, alu_bus=0x0001 in N+1, done0 in N+2 with result=8, done1 never.
REQ-029 SHALL cover: req1 div a=100, b=7 -> 8 EXEC cycles with busy=1, done1 at N+9 with result=14.
REQ-030 SHALL cover: req0 and req1 held together, both cmp -> with RR: grants alternate 0,1,0,1; without the macro: req0 granted every time while held.
REQ-031 SHALL cover: req0 mul a=6, b=7 granted, req1 raised during EXEC -> gnt1 only after done0 (result=42) and return to IDLE.
REQ-032 SHALL cover: op0=0x0003 -> done0 with op_err=1, result=0, and alu_bus=0 throughout.
REQ-033 SHALL cover: rst asserted mid-div -> all outputs 0 immediately, no done pulse, fresh request after release serviced normally.
